// File: rtl/rv32i_prefetch_pkg.sv
// Shared rv32i definitions: bus widths, opcode constants and small helpers
// used by the control path and the instruction prefetch queue.
package rv32i_prefetch_pkg;

  localparam int XLEN      = 32;
  localparam int INST_BITS = 16;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef logic [XLEN-1:0]      addr_t;
  typedef logic [INST_BITS-1:0] half_t;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic addr_t word_align(input addr_t pc);
    return pc & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/rv32i_prefetch_if.sv
// Memory-bus and instruction-side signals of the prefetch queue.
// master = prefetch unit, slave = memory plus consuming control logic.
interface rv32i_prefetch_if;
  import rv32i_prefetch_pkg::*;

  addr_t       mem_addr;
  logic        mem_req;
  logic        mem_gnt;
  half_t       mem_data;
  logic [31:0] instr;
  addr_t       instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  addr_t       redirect_pc;
  logic        empty;

  modport master (
    output mem_addr, mem_req, instr, instr_pc, instr_valid, empty,
    input  mem_gnt, mem_data, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_req, instr, instr_pc, instr_valid, empty,
    output mem_gnt, mem_data, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/rv32i_prefetch_halfword_fifo.sv
// Halfword queue: single-halfword write port, two-halfword read port,
// pop removes a whole 32-bit instruction, synchronous flush of pointers.
module rv32i_halfword_fifo
  import rv32i_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  half_t         wdata,
  input  logic          pop,
  output half_t         lo,
  output half_t         hi,
  output logic [CW-1:0] count
);

  half_t         mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;

  assign rd_next = rd_ptr + PW'(1);
  assign lo      = mem[rd_ptr];
  assign hi      = mem[rd_next];

  // Storage is cleared on reset so stale instructions never show on instr.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(2);
      count <= count + CW'(push) - (pop ? CW'(2) : CW'(0));
    end
  end

endmodule

// File: rtl/rv32i_prefetch.sv
// Instruction prefetch queue: fetches halfwords ahead of execution and
// presents whole instructions with their PC; redirect flushes and restarts.
module rv32i_prefetch
  import rv32i_prefetch_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter addr_t RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  rv32i_prefetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  addr_t         fetch_pc;
  addr_t         head_pc;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  half_t         lo;
  half_t         hi;

  // Request uses registered count only; a same-cycle pop never opens a slot.
  assign bus.mem_req     = ~reset & ~bus.redirect & (count < CW'(DEPTH));
  assign push            = bus.mem_req & bus.mem_gnt;
  assign bus.instr_valid = (count >= CW'(2)) & ~bus.redirect;
  assign pop             = bus.instr_valid & bus.instr_ready;

  assign bus.mem_addr = fetch_pc;
  assign bus.instr    = {hi, lo};
  assign bus.instr_pc = head_pc;
  assign bus.empty    = (count == '0);

  rv32i_halfword_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (bus.redirect),
    .push  (push),
    .wdata (bus.mem_data),
    .pop   (pop),
    .lo    (lo),
    .hi    (hi),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc <= word_align(bus.redirect_pc);
      head_pc  <= word_align(bus.redirect_pc);
    end else begin
      if (push) fetch_pc <= fetch_pc + addr_t'(2);
      if (pop)  head_pc  <= head_pc + addr_t'(4);
    end
  end

endmodule
